// File: rtl/serial_add_ctrl.sv
// Nibble-serial add/subtract controller: drives an external 4-bit combinational
// adder one slice per cycle and assembles the W-bit result, carry and overflow.
module serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [4*NIBBLES-1:0]   OPA,
    input  logic [4*NIBBLES-1:0]   OPB,
    input  logic                   SUB,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [4*NIBBLES-1:0]   RESULT,
    output logic                   CARRY,
    output logic                   OVF,
    output logic [3:0]             ADD_A,
    output logic [3:0]             ADD_B,
    output logic                   ADD_CIN,
    input  logic [3:0]             ADD_F,
    input  logic                   ADD_COUT
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;          // operand B already inverted for subtraction
    logic [KW-1:0]   k_r;
    logic [KW-1:0]   k_nxt_s;
    logic            carry_r;
    logic            last_s;
    logic [3:0]      a_nib_s;
    logic [3:0]      b_nib_s;
    logic [W-1:0]    result_r;
    logic [W-1:0]    result_s;
    logic            carry_out_r;
    logic            ovf_r;
    logic            busy_r;
    logic            done_r;
    logic [3:0]      add_a_r;
    logic [3:0]      add_b_r;
    logic            add_cin_r;

    assign last_s  = (k_r == KW'(NIBBLES - 1));

    assign BUSY    = busy_r;
    assign DONE    = done_r;
    assign RESULT  = result_r;
    assign CARRY   = carry_out_r;
    assign OVF     = ovf_r;
    assign ADD_A   = add_a_r;
    assign ADD_B   = add_b_r;
    assign ADD_CIN = add_cin_r;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Slice selection: operands for the next slice and result with the current slice merged in.
    always_comb begin
        k_nxt_s  = k_r + KW'(1);
        a_nib_s  = 4'h0;
        b_nib_s  = 4'h0;
        result_s = result_r;
        for (int i = 0; i < NIBBLES; i++) begin
            a_nib_s = (k_nxt_s == KW'(i)) ? a_r[4*i +: 4] : a_nib_s;
            b_nib_s = (k_nxt_s == KW'(i)) ? b_r[4*i +: 4] : b_nib_s;
            result_s[4*i +: 4] = (k_r == KW'(i)) ? ADD_F : result_r[4*i +: 4];
        end
    end

    // Operand capture, per-slice write-back and registered adder/status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            k_r         <= {KW{1'b0}};
            carry_r     <= 1'b0;
            result_r    <= {W{1'b0}};
            carry_out_r <= 1'b0;
            ovf_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            add_a_r     <= 4'h0;
            add_b_r     <= 4'h0;
            add_cin_r   <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == FIN);
            case (state_r)
                IDLE: begin
                    if (START) begin
                        a_r       <= OPA;
                        b_r       <= OPB ^ {W{SUB}};
                        k_r       <= {KW{1'b0}};
                        carry_r   <= SUB;
                        add_a_r   <= OPA[3:0];
                        add_b_r   <= OPB[3:0] ^ {4{SUB}};
                        add_cin_r <= SUB;
                    end
                end
                RUN: begin
                    result_r <= result_s;
                    carry_r  <= ADD_COUT;
                    if (last_s) begin
                        // ADD_F[3] is the final RESULT MSB being written this edge
                        k_r         <= {KW{1'b0}};
                        add_a_r     <= 4'h0;
                        add_b_r     <= 4'h0;
                        add_cin_r   <= 1'b0;
                        carry_out_r <= ADD_COUT;
                        ovf_r       <= (a_r[W-1] == b_r[W-1]) && (ADD_F[3] != a_r[W-1]);
                    end else begin
                        k_r       <= k_nxt_s;
                        add_a_r   <= a_nib_s;
                        add_b_r   <= b_nib_s;
                        add_cin_r <= ADD_COUT;
                    end
                end
                FIN: begin
                    k_r <= {KW{1'b0}};
                end
                default: begin
                    k_r <= {KW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven bench for serial_add_ctrl with a behavioural 4-bit adder.
module tb_serial_add_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        ovf;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_f;
    logic        add_cout;

    int compared = 0;
    int mismatched = 0;

    serial_add_ctrl #(.NIBBLES(4)) dut (
        .CLK(clk), .RST(rst), .START(start), .OPA(opa), .OPB(opb), .SUB(sub),
        .BUSY(busy), .DONE(done), .RESULT(result), .CARRY(carry), .OVF(ovf),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CIN(add_cin),
        .ADD_F(add_f), .ADD_COUT(add_cout)
    );

    assign {add_cout, add_f} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] r;
        logic        c;
        logic        o;
        logic [3:0]  cin;   // bit k = ADD_CIN seen during slice k
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input vec_t v);
        logic [15:0] bp;
        logic [3:0]  cinseq;
        int          lat;
        bp = v.b ^ {16{v.s}};
        @(negedge clk);
        opa = v.a; opb = v.b; sub = v.s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; opa = ~v.a; opb = ~v.b; sub = ~v.s;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ".adda0"}, {28'd0, add_a}, {28'd0, v.a[3:0]});
        chk({tag, ".addb0"}, {28'd0, add_b}, {28'd0, bp[3:0]});
        lat = 0;
        cinseq = 4'h0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 4) cinseq[c-1] = add_cin;
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ".latency"}, lat, 32'd5);
        chk({tag, ".cinseq"}, {28'd0, cinseq}, {28'd0, v.cin});
        chk({tag, ".result"}, {16'd0, result}, {16'd0, v.r});
        chk({tag, ".carry"}, {31'd0, carry}, {31'd0, v.c});
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, v.o});
        chk({tag, ".adders_idle"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, ".result_hold"}, {16'd0, result}, {16'd0, v.r});
    endtask

    initial begin
        int   dcnt;
        logic busy6;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 4'b1110};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0001};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
        vecs[8] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000};

        // Reset with START held high: reset must win.
        rst = 1'b1; start = 1'b1; opa = 16'h1234; opb = 16'h0FFF; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.result", {16'd0, result}, 32'd0);
        chk("rst.carry_ovf", {30'd0, carry, ovf}, 32'd0);
        chk("rst.adders", {23'd0, add_a, add_b, add_cin}, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle.busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // START re-pulsed with other operands during RUN and during FIN.
        @(negedge clk);
        opa = 16'h1234; opb = 16'h0FFF; sub = 1'b0; start = 1'b1;
        dcnt = 0;
        busy6 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (c == 6) busy6 = busy;
            start = (c == 2 || c == 5);
            if (start) begin
                opa = 16'hFFFF; opb = 16'h0001; sub = 1'b1;
            end
        end
        chk("restart.done_count", dcnt, 32'd1);
        chk("restart.busy_after_fin", {31'd0, busy6}, 32'd0);
        chk("restart.result", {16'd0, result}, 32'h2233);
        chk("restart.carry_ovf", {30'd0, carry, ovf}, 32'd0);

        // Reset during RUN slice 2 aborts with no DONE.
        @(negedge clk);
        opa = 16'h1234; opb = 16'h0FFF; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.result", {16'd0, result}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort.no_done", dcnt, 32'd0);
        run_op("after_abort", vecs[8]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port CLK, in, 1: single clock; all state on rising edge.
REQ-003 SHALL have port RST, in, 1: reset, synchronous and active-high.
REQ-004 SHALL have port START, in, 1: request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port OPA, in, W: operand A; captured when START is accepted.
REQ-006 SHALL have port OPB, in, W: operand B; captured when START is accepted.
REQ-007 SHALL have port SUB, in, 1: 0 = A+B, 1 = A-B; captured when START is accepted.
REQ-008 SHALL have port BUSY, out, 1: high whenever state is not IDLE.
REQ-009 SHALL have port DONE, out, 1: one-cycle pulse; result valid.
REQ-010 SHALL have port RESULT, out, W: sum or difference.
REQ-011 SHALL have port CARRY, out, 1: final carry-out; for SUB, 1 = no borrow.
REQ-012 SHALL have port OVF, out, 1: two's-complement overflow.
REQ-013 SHALL have port ADD_A, out, 4: slice of A to the external 4-bit adder.
REQ-014 SHALL have port ADD_B, out, 4: slice of B, or of ~B when SUB, to the adder.
REQ-015 SHALL have port ADD_CIN, out, 1: adder carry-in.
REQ-016 SHALL have port ADD_F, in, 4: combinational adder sum, same cycle.
REQ-017 SHALL have port ADD_COUT, in, 1: combinational adder carry-out, same cycle.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, FIN.
- IDLE -> RUN on START=1: latch OPA, OPB, SUB; slice index k=0; carry register = SUB.
- RUN -> FIN after slice k=NIBBLES-1.
- FIN -> IDLE unconditionally.
REQ-019 SHALL, in RUN at slice k, drive the adder ports from latched values and write back:
- ADD_A = A[4k+3:4k]; ADD_B = B[4k+3:4k] XOR {4{SUB}}; ADD_CIN = carry register.
- Clock ADD_F into RESULT[4k+3:4k] and ADD_COUT into the carry register; then k+1.
REQ-020 SHALL drive ADD_A, ADD_B, ADD_CIN to 0 outside RUN.
REQ-021 SHALL assert DONE only in FIN, for exactly one cycle; latency is START-accept edge to DONE = NIBBLES+1 cycles.
REQ-022 SHALL present CARRY = final carry register in FIN.
REQ-023 SHALL compute OVF = (A[W-1] == B'[W-1]) AND (RESULT[W-1] != A[W-1]), where B' = B XOR {W{SUB}}.
REQ-024 SHALL hold RESULT, CARRY, OVF stable from FIN until the next accepted START.
REQ-025 SHALL ignore START while BUSY=1, including in FIN; a new START is accepted no earlier than the cycle after FIN.
REQ-026 SHALL not respond to OPA, OPB or SUB changes after capture.

Reset
REQ-027 SHALL, on RST=1 at a clock edge, enter IDLE and clear k, the carry register, RESULT, CARRY, OVF, BUSY, DONE, and the ADD_* outputs to 0.
REQ-028 SHALL, on RST during RUN or FIN, abort the operation with no DONE pulse; RST takes priority over a simultaneous START.

Verification
REQ-029 SHALL cover: 0x1234+0x0FFF, SUB=0 -> RESULT=0x2233, CARRY=0, OVF=0, DONE exactly 5 cycles after START edge, ADD_CIN sequence 0,1,1,1.
REQ-030 SHALL cover: 0xFFFF+0x0001 -> RESULT=0x0000, CARRY=1, OVF=0 (carry ripples through all slices).
REQ-031 SHALL cover: 0x7FFF+0x0001 -> RESULT=0x8000, OVF=1, CARRY=0; and 0x8000-0x0001 -> 0x7FFF, OVF=1, CARRY=1.
REQ-032 SHALL cover: 0x0005-0x0007 -> RESULT=0xFFFE, CARRY=0, OVF=0, ADD_B slice 0 = 0x8, first ADD_CIN=1.
REQ-033 SHALL cover: START re-pulsed with new operands during RUN and during FIN -> ignored; first result returned; single DONE.
REQ-034 SHALL cover: RST asserted at RUN slice 2 -> next cycle BUSY=0, RESULT=0, no DONE; a following 0x0001+0x0001 returns 0x0002.
